// File: rtl/alu_cmd_scheduler.sv
// In-order command front-end for the registered 8-bit ALU, one operation in flight at a time.
// Latency: ALU_LATENCY+2 edges from accept to rsp_valid; one result per ALU_LATENCY+2 cycles.
// Backpressure: cmd_ready drops when the FIFO is full; rsp_* is held stable while rsp_ready is low.
module alu_cmd_scheduler #(
    parameter int DEPTH       = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic [2:0] cmd_sel,
    input  logic [3:0] cmd_tag,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [7:0] alu_out,
    input  logic       alu_zero,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_zero,
    output logic [3:0] rsp_tag,
    output logic       busy
);

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] sel;
        logic [3:0] tag;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_t;

    localparam int             CW       = $clog2(ALU_LATENCY + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(ALU_LATENCY);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [3:0]    cur_tag;

    cmd_t push_dat;
    cmd_t head_dat;
    logic fifo_full;
    logic fifo_empty;
    logic push_vld;
    logic pop_vld;
    logic capture;
    logic rsp_clr;

    assign push_dat = '{a: cmd_a, b: cmd_b, sel: cmd_sel, tag: cmd_tag};
    // No bypass when full: a pop in the same cycle does not open the door.
    assign push_vld = cmd_valid && !fifo_full;

    fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_vld),
        .push_dat (push_dat),
        .pop      (pop_vld),
        .pop_dat  (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (!fifo_empty) state_nxt = S_WAIT;
            S_WAIT: if (cnt == '0) state_nxt = S_HOLD;
            S_HOLD: if (rsp_valid && rsp_ready) state_nxt = fifo_empty ? S_IDLE : S_WAIT;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pop_vld = 1'b0;
        capture = 1'b0;
        rsp_clr = 1'b0;
        case (state)
            S_IDLE: pop_vld = !fifo_empty;
            S_WAIT: capture = (cnt == '0);
            S_HOLD: begin
                rsp_clr = rsp_valid && rsp_ready;
                pop_vld = rsp_valid && rsp_ready && !fifo_empty;
            end
            default: ;
        endcase
    end

    // The tag is staged internally so rsp_tag only moves together with the captured result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            cur_tag   <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_tag   <= '0;
        end else begin
            if (pop_vld) begin
                alu_a   <= head_dat.a;
                alu_b   <= head_dat.b;
                alu_sel <= head_dat.sel;
                cur_tag <= head_dat.tag;
                cnt     <= CNT_INIT;
            end else if (state == S_WAIT && cnt != '0) begin
                cnt <= cnt - CNT_ONE;
            end
            if (capture) begin
                rsp_valid <= 1'b1;
                rsp_data  <= alu_out;
                rsp_zero  <= alu_zero;
                rsp_tag   <= cur_tag;
            end else if (rsp_clr) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    assign cmd_ready = !fifo_full;
    assign busy      = !fifo_empty || (state != S_IDLE);

endmodule

// Generic synchronous FIFO with wrap-bit pointers; head is visible on pop_dat.
// Latency: a pushed entry appears at the head the cycle after its push edge.
// Backpressure: caller must gate push with !full and pop with !empty.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    assign pop_dat = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: tb/tb_alu_cmd_scheduler.sv
// Scoreboard bench for alu_cmd_scheduler with registered ALU models at latency 1 and 3.
module tb_alu_cmd_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       cmd_valid, cmd_ready;
    logic [7:0] cmd_a, cmd_b;
    logic [2:0] cmd_sel;
    logic [3:0] cmd_tag;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [2:0] alu_sel;
    logic       alu_zero;
    logic       rsp_valid, rsp_ready, rsp_zero, busy;
    logic [7:0] rsp_data;
    logic [3:0] rsp_tag;

    logic       l3_cmd_valid, l3_cmd_ready;
    logic [7:0] l3_cmd_a, l3_cmd_b;
    logic [2:0] l3_cmd_sel;
    logic [3:0] l3_cmd_tag;
    logic [7:0] l3_alu_a, l3_alu_b, l3_alu_out;
    logic [2:0] l3_alu_sel;
    logic       l3_alu_zero;
    logic       l3_rsp_valid, l3_rsp_ready, l3_rsp_zero, l3_busy;
    logic [7:0] l3_rsp_data;
    logic [3:0] l3_rsp_tag;

    logic man_rdy, rand_rdy, rand_mode;
    assign rsp_ready = rand_mode ? rand_rdy : man_rdy;

    alu_cmd_scheduler #(.DEPTH(4), .ALU_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_tag(rsp_tag),
        .busy(busy)
    );

    alu_cmd_scheduler #(.DEPTH(4), .ALU_LATENCY(3)) dut_l3 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(l3_cmd_valid), .cmd_ready(l3_cmd_ready),
        .cmd_a(l3_cmd_a), .cmd_b(l3_cmd_b), .cmd_sel(l3_cmd_sel), .cmd_tag(l3_cmd_tag),
        .alu_a(l3_alu_a), .alu_b(l3_alu_b), .alu_sel(l3_alu_sel),
        .alu_out(l3_alu_out), .alu_zero(l3_alu_zero),
        .rsp_valid(l3_rsp_valid), .rsp_ready(l3_rsp_ready),
        .rsp_data(l3_rsp_data), .rsp_zero(l3_rsp_zero), .rsp_tag(l3_rsp_tag),
        .busy(l3_busy)
    );

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
        case (s)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~a;
            3'd6:    return a << 1;
            default: return a >> 1;
        endcase
    endfunction

    // Reference ALUs: one register stage, and three stages for the long-latency instance.
    logic [7:0] p1_d, p2_d;
    logic       p1_z, p2_z;
    always_ff @(posedge clk) begin
        alu_out     <= alu_f(alu_a, alu_b, alu_sel);
        alu_zero    <= (alu_f(alu_a, alu_b, alu_sel) == 8'd0);
        p1_d        <= alu_f(l3_alu_a, l3_alu_b, l3_alu_sel);
        p1_z        <= (alu_f(l3_alu_a, l3_alu_b, l3_alu_sel) == 8'd0);
        p2_d        <= p1_d;
        p2_z        <= p1_z;
        l3_alu_out  <= p2_d;
        l3_alu_zero <= p2_z;
    end

    always @(posedge clk) begin
        #1 rand_rdy = 1'($urandom_range(0, 1));
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0] d;
        logic       z;
        logic [3:0] t;
    } exp_t;

    exp_t       sb_q[$];
    int         hs_cyc[$];
    logic [7:0] exp_d;
    logic       exp_z;
    logic       stall_prev;
    logic [7:0] prev_d;
    logic       prev_z;
    logic [3:0] prev_t;

    // Monitor: pushes expectations on accept, pops on response, checks stability while stalled.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) sb_q.push_back('{d: exp_d, z: exp_z, t: cmd_tag});
            if (stall_prev) begin
                check("stall_valid", rsp_valid, 1);
                check("stall_data", rsp_data, prev_d);
                check("stall_zero", rsp_zero, prev_z);
                check("stall_tag", rsp_tag, prev_t);
            end
            if (rsp_valid && rsp_ready) begin
                hs_cyc.push_back(cyc);
                if (sb_q.size() == 0) begin
                    check("rsp_spurious", rsp_valid, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_data", rsp_data, e.d);
                    check("rsp_zero", rsp_zero, e.z);
                    check("rsp_tag", rsp_tag, e.t);
                end
            end
            stall_prev = rsp_valid && !rsp_ready;
            prev_d     = rsp_data;
            prev_z     = rsp_zero;
            prev_t     = rsp_tag;
        end
    end

    task automatic offer(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s,
                         input logic [3:0] t, input logic [7:0] ed, input logic ez);
        cmd_a     = a;
        cmd_b     = b;
        cmd_sel   = s;
        cmd_tag   = t;
        exp_d     = ed;
        exp_z     = ez;
        cmd_valid = 1'b1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s,
                        input logic [3:0] t, input logic [7:0] ed, input logic ez);
        logic acc;
        int   k;
        acc = 1'b0;
        k   = 0;
        offer(a, b, s, t, ed, ez);
        while (!acc && k < 200) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
            #1;
            k++;
        end
        cmd_valid = 1'b0;
        if (!acc) check("send_timeout", acc, 1);
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((sb_q.size() != 0 || rsp_valid) && k < 300) begin
            @(negedge clk);
            k++;
        end
        check(tag, sb_q.size(), 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_alu_a"}, alu_a, 0);
        check({tag, "_alu_b"}, alu_b, 0);
        check({tag, "_alu_sel"}, alu_sel, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_rsp_zero"}, rsp_zero, 0);
        check({tag, "_rsp_tag"}, rsp_tag, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int   k;
        int   nrdy;
        int   nval;
        logic acc;
        logic [7:0] ra, rb;
        logic [2:0] rs;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sel = '0; cmd_tag = '0;
        exp_d = '0; exp_z = 1'b0; man_rdy = 1'b0; rand_mode = 1'b0;
        l3_cmd_valid = 1'b0; l3_cmd_a = '0; l3_cmd_b = '0; l3_cmd_sel = '0; l3_cmd_tag = '0;
        l3_rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset("rst0");
        check("rst0_l3_busy", l3_busy, 0);

        // Single add: latency and alu_a hold.
        @(posedge clk); #1;
        offer(8'd10, 8'd5, 3'd0, 4'd3, 8'd15, 1'b0);
        @(negedge clk);
        check("t1_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        k = 0;
        while (k < 20) begin
            @(posedge clk); k++;
            @(negedge clk);
            if (rsp_valid) break;
        end
        check("t1_latency", k, 3);
        check("t1_alu_a", alu_a, 10);
        check("t1_busy", busy, 1);
        repeat (2) @(negedge clk);
        check("t1_hold_tag", rsp_tag, 3);
        @(posedge clk); #1 man_rdy = 1'b1;
        @(posedge clk); #1 man_rdy = 1'b0;
        repeat (2) @(negedge clk);
        check("t1_idle_alu_a", alu_a, 10);
        check("t1_idle_busy", busy, 0);
        check("t1_sb_empty", sb_q.size(), 0);

        // Back-to-back ops, in-order tags, 3-cycle throughput.
        @(posedge clk); #1 man_rdy = 1'b1;
        hs_cyc.delete();
        send(8'd10, 8'd5, 3'd1, 4'd0, 8'd5, 1'b0);
        send(8'd10, 8'd5, 3'd2, 4'd1, 8'd0, 1'b1);
        send(8'd10, 8'd5, 3'd3, 4'd2, 8'd15, 1'b0);
        send(8'd10, 8'd5, 3'd4, 4'd3, 8'd15, 1'b0);
        drain("t2_drain");
        check("t2_count", hs_cyc.size(), 4);
        for (int i = 1; i < hs_cyc.size(); i++) check("t2_gap", hs_cyc[i] - hs_cyc[i-1], 3);

        // Stall with full FIFO.
        @(posedge clk); #1 man_rdy = 1'b0;
        for (int i = 1; i <= 5; i++) send(8'(i), 8'd1, 3'd0, 4'(4 + i), 8'(i + 1), 1'b0);
        @(negedge clk);
        check("t3_full", cmd_ready, 0);
        check("t3_busy", busy, 1);
        @(posedge clk); #1;
        offer(8'd20, 8'd3, 3'd1, 4'd10, 8'd17, 1'b0);
        nrdy = 0;
        repeat (8) begin
            @(negedge clk);
            nrdy += int'(cmd_ready);
        end
        check("t3_blocked", nrdy, 0);
        @(posedge clk); #1 man_rdy = 1'b1;
        @(posedge clk); #1 man_rdy = 1'b0;
        acc = 1'b0;
        k = 0;
        while (!acc && k < 20) begin
            @(negedge clk);
            acc = cmd_ready;
            k++;
        end
        @(posedge clk); #1 cmd_valid = 1'b0;
        check("t3_accept", acc, 1);
        repeat (4) @(posedge clk);
        #1 man_rdy = 1'b1;
        drain("t3_drain");

        // Boundary operands.
        send(8'h00, 8'h00, 3'd0, 4'd1, 8'h00, 1'b1);
        send(8'h81, 8'h00, 3'd6, 4'd2, 8'h02, 1'b0);
        send(8'h81, 8'h00, 3'd5, 4'd3, 8'h7E, 1'b0);
        drain("t4_drain");

        // Random traffic with random response backpressure.
        rand_mode = 1'b1;
        for (int i = 0; i < 12; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 3'($urandom_range(0, 7));
            send(ra, rb, rs, 4'(i), alu_f(ra, rb, rs), alu_f(ra, rb, rs) == 8'd0);
        end
        drain("rand_drain");
        rand_mode = 1'b0;

        // Reset while in WAIT drops everything.
        @(posedge clk); #1 man_rdy = 1'b0;
        send(8'd1, 8'd2, 3'd0, 4'd4, 8'd3, 1'b0);
        send(8'd3, 8'd4, 3'd0, 4'd5, 8'd7, 1'b0);
        send(8'd5, 8'd6, 3'd0, 4'd6, 8'd11, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset("t5");
        @(posedge clk); #1 man_rdy = 1'b1;
        nval = 0;
        repeat (8) begin
            @(negedge clk);
            nval += int'(rsp_valid);
        end
        check("t5_no_rsp", nval, 0);
        @(posedge clk); #1;
        send(8'd7, 8'd8, 3'd0, 4'd9, 8'd15, 1'b0);
        drain("t5_drain");

        // Latency-3 instance.
        @(posedge clk); #1;
        l3_cmd_a = 8'd200; l3_cmd_b = 8'd100; l3_cmd_sel = 3'd0; l3_cmd_tag = 4'd5;
        l3_cmd_valid = 1'b1;
        @(negedge clk);
        check("l3_cmd_ready", l3_cmd_ready, 1);
        @(posedge clk); #1 l3_cmd_valid = 1'b0;
        k = 0;
        while (k < 20) begin
            @(posedge clk); k++;
            @(negedge clk);
            if (l3_rsp_valid) break;
        end
        check("l3_latency", k, 5);
        check("l3_rsp_data", l3_rsp_data, 44);
        check("l3_rsp_zero", l3_rsp_zero, 0);
        check("l3_rsp_tag", l3_rsp_tag, 5);
        @(posedge clk); #1 l3_rsp_ready = 1'b1;
        @(posedge clk); #1 l3_rsp_ready = 1'b0;
        @(negedge clk);
        check("l3_rsp_clear", l3_rsp_valid, 0);
        check("l3_busy_end", l3_busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
